// File: rtl/aes_pkg.sv
// Shared AES constants and the sequencer state type.
package aes_pkg;
    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;
endpackage

// File: rtl/inv_sbox.sv
// Combinational FIPS-197 inverse S-box, one byte in, one byte out.
module inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Row r of the table holds outputs for inputs 0xr0..0xrf; entry 0 sits at the MSB.
    localparam logic [2047:0] TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign dout = TBL[11'd2047 - {din, 3'b000} -: 8];
endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes: LANES inverse S-boxes walk the 16-byte state over 16/LANES cycles.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);
    localparam int STEPS = AES_BYTES / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int LW    = LANES * 8;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    fsm_e                   fsm_q, fsm_d;
    logic [AES_STATE_W-1:0] st_q, st_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [6:0]             sh;
    logic [LANES-1:0][7:0]  lane_in, lane_out;
    logic [LW-1:0]          lane_flat;
    logic [AES_STATE_W-1:0] lane_mask, lane_upd;

    // Bit offset of the current byte window, measured from the MSB.
    assign sh = 7'(cnt_q) * 7'(LW);

    // Lane LANES-1 (MSB of the packed array) carries the lowest-numbered byte of the window.
    assign lane_in   = LW'((st_q << sh) >> (AES_STATE_W - LW));
    assign lane_flat = lane_out;
    assign lane_upd  = (AES_STATE_W'(lane_flat) << (AES_STATE_W - LW)) >> sh;
    assign lane_mask = (AES_STATE_W'({LW{1'b1}}) << (AES_STATE_W - LW)) >> sh;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            inv_sbox u_inv_sbox (
                .din  (lane_in[l]),
                .dout (lane_out[l])
            );
        end
    endgenerate

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        cnt_d = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    st_d  = in_state;
                    cnt_d = '0;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                st_d = (st_q & ~lane_mask) | lane_upd;
                if (cnt_q == CNT_W'(STEPS - 1)) fsm_d = DONE;
                else                            cnt_d = cnt_q + CNT_W'(1);
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN) || (fsm_q == DONE);
    assign out_state = st_q;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed and scoreboard bench for inv_sub_bytes_seq at LANES = 4, 1 and 16.
module tb_inv_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready;
    logic [127:0] in_state;
    logic         rdy [3];
    logic         ov  [3];
    logic         bsy [3];
    logic [127:0] os  [3];

    int           sel = 0;
    logic         s_rdy, s_ov, s_bsy;
    logic [127:0] s_os;
    int           tests = 0;
    int           fails = 0;

    localparam logic [127:0] V_FIPS   = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] R_FIPS   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R_ROW0   = 128'h52096ad53036a538bf40a39e81f3d7fb;

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_state(in_state),
        .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bsy[0]));
    inv_sub_bytes_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_state(in_state),
        .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bsy[1]));
    inv_sub_bytes_seq #(.LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_state(in_state),
        .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bsy[2]));

    always_comb begin
        s_rdy = rdy[sel];
        s_ov  = ov[sel];
        s_bsy = bsy[sel];
        s_os  = os[sel];
    end

    // Reference built from GF(2^8) inversion and the inverse affine map, not from a table.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xt(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [7:0] b);
        logic [7:0] x, p, r;
        x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = ref_byte(s[127-8*i -: 8]);
        return o;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int s, input logic [127:0] v, output int lat, output logic [127:0] res);
        sel = s; in_state = v; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!s_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = s_os;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; sel = 0;
        #2;
        tests++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", s_rdy); end
        tests++; if (s_ov !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", s_ov); end
        tests++; if (s_bsy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", s_bsy); end
        tests++; if ({os[0], os[1], os[2]} !== 384'h0) begin
            fails++; $display("FAIL reset_out_state: got %h %h %h want 0", os[0], os[1], os[2]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_zero_lanes4();
        int lat; logic [127:0] res;
        do_reset();
        run_vec(0, {16{8'h63}}, lat, res);
        tests++; if (lat !== 4) begin fails++; $display("FAIL zero_latency: got %0d want 4", lat); end
        tests++; if (res !== 128'h0) begin fails++; $display("FAIL zero_result: got %h want 0", res); end
        tests++; if ({s_rdy, s_bsy} !== 2'b01) begin
            fails++; $display("FAIL zero_done_flags: got rdy=%b busy=%b want rdy=0 busy=1", s_rdy, s_bsy);
        end
        release_out();
        tests++; if ({s_ov, s_rdy} !== 2'b01) begin
            fails++; $display("FAIL zero_release: got ov=%b rdy=%b want ov=0 rdy=1", s_ov, s_rdy);
        end
    endtask

    task automatic test_fips_vectors();
        int lat; logic [127:0] res;
        do_reset();
        run_vec(0, V_FIPS, lat, res);
        tests++; if (res !== R_FIPS || lat !== 4) begin
            fails++; $display("FAIL fips_vector: got %h lat %0d want %h lat 4", res, lat, R_FIPS);
        end
        release_out();
        run_vec(0, R_FIPS, lat, res);
        tests++; if (res !== R_ROW0 || lat !== 4) begin
            fails++; $display("FAIL row0_vector: got %h lat %0d want %h lat 4", res, lat, R_ROW0);
        end
        release_out();
    endtask

    task automatic test_done_hold();
        int lat; logic [127:0] res;
        do_reset();
        run_vec(0, V_FIPS, lat, res);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            tests++; if ({s_ov, s_rdy, s_os} !== {1'b1, 1'b0, R_FIPS}) begin
                fails++; $display("FAIL done_hold[%0d]: got ov=%b rdy=%b %h want ov=1 rdy=0 %h", i, s_ov, s_rdy, s_os, R_FIPS);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++; if ({s_ov, s_rdy, s_bsy} !== 3'b010) begin
            fails++; $display("FAIL done_release: got ov=%b rdy=%b busy=%b want 0 1 0", s_ov, s_rdy, s_bsy);
        end
        in_valid = 1'b0;
        run_vec(0, {16{8'h63}}, lat, res);
        tests++; if (res !== 128'h0 || lat !== 4) begin
            fails++; $display("FAIL after_hold: got %h lat %0d want 0 lat 4", res, lat);
        end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [127:0] res;
        do_reset();
        sel = 0; in_state = V_FIPS; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests++; if ({s_rdy, s_ov, s_bsy, s_os} !== {3'b100, 128'h0}) begin
            fails++; $display("FAIL mid_run_reset: got rdy=%b ov=%b busy=%b %h want 1 0 0 0", s_rdy, s_ov, s_bsy, s_os);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec(0, R_FIPS, lat, res);
        tests++; if (res !== R_ROW0 || lat !== 4) begin
            fails++; $display("FAIL post_reset_vector: got %h lat %0d want %h lat 4", res, lat, R_ROW0);
        end
        release_out();
    endtask

    task automatic test_lanes(input int s, input int exp_lat);
        int lat; logic [127:0] res;
        do_reset();
        run_vec(s, {16{8'h16}}, lat, res);
        tests++; if (res !== {16{8'hff}} || lat !== exp_lat) begin
            fails++; $display("FAIL lanes_sel%0d_16s: got %h lat %0d want all ff lat %0d", s, res, lat, exp_lat);
        end
        release_out();
        run_vec(s, R_FIPS, lat, res);
        tests++; if (res !== R_ROW0 || lat !== exp_lat) begin
            fails++; $display("FAIL lanes_sel%0d_row0: got %h lat %0d want %h lat %0d", s, res, lat, R_ROW0, exp_lat);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [127:0] q[$];
        int acc = 0, cyc = 0, last_acc = -1;
        do_reset();
        sel = 0; in_valid = 1'b1; out_ready = 1'b1;
        while ((acc < 20 || q.size() > 0) && cyc < 400) begin
            in_valid = (acc < 20);
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (s_ov) begin
                tests++; if (q.size() == 0 || s_os !== q[0]) begin
                    fails++; $display("FAIL b2b_result: got %h want %h", s_os, (q.size() > 0) ? q[0] : 128'hx);
                end
                if (q.size() > 0) void'(q.pop_front());
            end
            if (s_rdy && in_valid) begin
                q.push_back(ref_state(in_state));
                if (last_acc >= 0) begin
                    tests++; if (cyc - last_acc !== 6) begin
                        fails++; $display("FAIL b2b_spacing: got %0d want 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        tests++; if (cyc >= 400) begin fails++; $display("FAIL b2b_timeout: got %0d accepted want 20", acc); end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] q[$];
        logic [127:0] hold_val = '0;
        logic         hold = 1'b0;
        int acc = 0, cyc = 0;
        do_reset();
        sel = 0;
        while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
            in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (hold) begin
                tests++; if (s_ov !== 1'b1 || s_os !== hold_val) begin
                    fails++; $display("FAIL rand_stall: got ov=%b %h want ov=1 %h", s_ov, s_os, hold_val);
                end
            end
            hold = s_ov && !out_ready;
            hold_val = s_os;
            if (s_ov && out_ready) begin
                tests++; if (q.size() == 0 || s_os !== q[0]) begin
                    fails++; $display("FAIL rand_result: got %h want %h", s_os, (q.size() > 0) ? q[0] : 128'hx);
                end
                if (q.size() > 0) void'(q.pop_front());
            end
            if (s_rdy && in_valid) begin
                q.push_back(ref_state(in_state));
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        tests++; if (cyc >= 20000) begin fails++; $display("FAIL rand_timeout: got %0d accepted want 1000", acc); end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_lanes4();
        test_fips_vectors();
        test_done_hold();
        test_reset_mid_run();
        test_lanes(1, 16);
        test_lanes(2, 1);
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
